// File: rtl/vending_machine_multi.sv
// Multi-product vending machine: Rs5/Rs10 coins, priced products,
// coin-by-coin change return and cancel refund.
module vending_machine_multi #(
  parameter int CREDIT_W = 5,
  parameter int NPROD = 4,
  parameter int SEL_W = 2,
  parameter int MAX_CREDIT = 20,
  parameter logic [NPROD*CREDIT_W-1:0] PRICES =
    {5'd6, 5'd5, 5'd4, 5'd3}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          in,
  input  logic [SEL_W-1:0]    sel,
  input  logic                buy,
  input  logic                cancel,
  output logic                out,
  output logic [SEL_W-1:0]    prod,
  output logic [1:0]          change,
  output logic [CREDIT_W-1:0] credit,
  output logic                reject,
  output logic                short,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE, CREDIT, DISPENSE, CHANGE
  } state_t;

  localparam logic [CREDIT_W:0] MAX_C =
    (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] ONE = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] TWO = CREDIT_W'(2);

  state_t state, state_n;
  logic [CREDIT_W-1:0] credit_n;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W-1:0] paid;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] coin_val;
  logic                coin_ok;
  logic                coin_any;
  logic                out_n;
  logic [SEL_W-1:0]    prod_n;
  logic [1:0]          change_n;
  logic                reject_n;
  logic                short_n;
  logic                busy_n;

  function automatic logic [1:0] coin_of(
    input logic [CREDIT_W-1:0] c
  );
    return (c >= TWO) ? 2'b10 : 2'b01;
  endfunction

  assign price    = PRICES[int'(sel)*CREDIT_W +: CREDIT_W];
  assign coin_ok  = (in == 2'b01) || (in == 2'b10);
  assign coin_any = (in != 2'b00);
  assign coin_val = (in == 2'b10) ? TWO :
                    (in == 2'b01) ? ONE : '0;
  assign sum      = {1'b0, credit} + {1'b0, coin_val};
  // change register always holds the coin going out this cycle
  assign paid     = (change == 2'b10) ? TWO : ONE;

  always_comb begin
    state_n  = state;
    credit_n = credit;
    out_n    = 1'b0;
    prod_n   = '0;
    change_n = 2'b00;
    reject_n = 1'b0;
    short_n  = 1'b0;
    unique case (state)
      IDLE, CREDIT: begin
        if (cancel && credit != '0) begin
          state_n  = CHANGE;
          change_n = coin_of(credit);
          reject_n = coin_any;
        end else if (buy && !cancel) begin
          reject_n = coin_any;
          if (credit >= price) begin
            state_n  = DISPENSE;
            credit_n = credit - price;
            out_n    = 1'b1;
            prod_n   = sel;
          end else begin
            short_n = 1'b1;
          end
        end else if (coin_ok && sum <= MAX_C) begin
          credit_n = sum[CREDIT_W-1:0];
          state_n  = CREDIT;
        end else begin
          reject_n = coin_any;
        end
      end
      DISPENSE: begin
        reject_n = coin_any;
        if (credit != '0) begin
          state_n  = CHANGE;
          change_n = coin_of(credit);
        end else begin
          state_n = IDLE;
        end
      end
      CHANGE: begin
        reject_n = coin_any;
        credit_n = credit - paid;
        if (credit_n == '0) begin
          state_n = IDLE;
        end else begin
          change_n = coin_of(credit_n);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy_n = (state_n == DISPENSE) ||
                  (state_n == CHANGE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      credit <= '0;
      out    <= 1'b0;
      prod   <= '0;
      change <= 2'b00;
      reject <= 1'b0;
      short  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      credit <= credit_n;
      out    <= out_n;
      prod   <= prod_n;
      change <= change_n;
      reject <= reject_n;
      short  <= short_n;
      busy   <= busy_n;
    end
  end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in;
  logic [1:0] sel;
  logic       buy;
  logic       cancel;
  logic       out;
  logic [1:0] prod;
  logic [1:0] change;
  logic [4:0] credit;
  logic       reject;
  logic       short;
  logic       busy;

  int checks = 0;
  int failures = 0;

  // model: phase 0 = taking coins, 1 = dispensing, 2 = refunding
  int m_credit = 0;
  int m_phase = 0;
  int m_chg = 0;
  logic       e_out, e_rej, e_short;
  logic [1:0] e_prod;
  logic [12:0] exp_v;
  logic [12:0] obs;

  assign obs = {out, prod, change, credit, reject, short, busy};

  vending_machine_multi dut (
    .clk(clk), .rst(rst), .in(in), .sel(sel),
    .buy(buy), .cancel(cancel), .out(out),
    .prod(prod), .change(change), .credit(credit),
    .reject(reject), .short(short), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int coin_for(input int c);
    return (c >= 2) ? 2 : ((c > 0) ? 1 : 0);
  endfunction

  task automatic step(
    input logic r, input logic [1:0] c,
    input logic [1:0] s, input logic b, input logic x
  );
    int price;
    @(negedge clk);
    rst = r; in = c; sel = s; buy = b; cancel = x;
    e_out = 0; e_prod = 0; e_rej = 0; e_short = 0;
    if (r) begin
      m_credit = 0; m_phase = 0; m_chg = 0;
    end else if (m_phase == 1) begin
      e_rej = (c != 0);
      m_chg = coin_for(m_credit);
      m_phase = (m_credit > 0) ? 2 : 0;
    end else if (m_phase == 2) begin
      e_rej = (c != 0);
      m_credit -= m_chg;
      m_chg = coin_for(m_credit);
      if (m_credit == 0) m_phase = 0;
    end else begin
      m_chg = 0;
      if (x && m_credit > 0) begin
        e_rej = (c != 0);
        m_phase = 2;
        m_chg = coin_for(m_credit);
      end else if (b && !x) begin
        e_rej = (c != 0);
        price = 3 + int'(s);
        if (m_credit >= price) begin
          m_credit -= price;
          e_out = 1; e_prod = s; m_phase = 1;
        end else begin
          e_short = 1;
        end
      end else if ((c == 1 || c == 2) &&
                   m_credit + int'(c) <= 20) begin
        m_credit += int'(c);
      end else begin
        e_rej = (c != 0);
      end
    end
    exp_v = {e_out, e_prod, 2'(m_chg), 5'(m_credit),
             e_rej, e_short, 1'(m_phase != 0)};
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] c);
    step(0, c, 0, 0, 0);
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 2'b10, 2'd3, 1, 1);
    checks++;
    if (obs !== 13'd0) begin
      failures++;
      $display("FAIL reset obs=%b exp=%b", obs, 13'd0);
    end
  endtask

  task automatic test_buy_with_change();
    logic [12:0] want [5];
    want[0] = {1'b0, 2'd0, 2'b00, 5'd2, 3'b000};
    want[1] = {1'b0, 2'd0, 2'b00, 5'd4, 3'b000};
    want[2] = {1'b1, 2'd0, 2'b00, 5'd1, 3'b001};
    want[3] = {1'b0, 2'd0, 2'b01, 5'd1, 3'b001};
    want[4] = {1'b0, 2'd0, 2'b00, 5'd0, 3'b000};
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0, 1: coin(2'b10);
        2: step(0, 0, 2'd0, 1, 0);
        default: nop();
      endcase
      checks++;
      if (obs !== want[i]) begin
        failures++;
        $display("FAIL buy_change[%0d] obs=%b exp=%b",
                 i, obs, want[i]);
      end
    end
  endtask

  task automatic test_exact_buy();
    step(1, 0, 0, 0, 0);
    repeat (3) coin(2'b10);
    checks++;
    if (credit !== 5'd6) begin
      failures++;
      $display("FAIL exact_credit got=%0d exp=6", credit);
    end
    step(0, 0, 2'd3, 1, 0);
    checks++;
    if (obs !== {1'b1, 2'd3, 2'b00, 5'd0, 3'b001}) begin
      failures++;
      $display("FAIL exact_dispense obs=%b", obs);
    end
    nop();
    checks++;
    if (obs !== 13'd0) begin
      failures++;
      $display("FAIL exact_idle obs=%b exp=0", obs);
    end
  endtask

  task automatic test_cancel();
    logic [12:0] want [3];
    want[0] = {1'b0, 2'd0, 2'b10, 5'd3, 3'b001};
    want[1] = {1'b0, 2'd0, 2'b01, 5'd1, 3'b001};
    want[2] = {1'b0, 2'd0, 2'b00, 5'd0, 3'b000};
    step(1, 0, 0, 0, 0);
    coin(2'b10);
    coin(2'b01);
    for (int i = 0; i < 3; i++) begin
      if (i == 0) step(0, 0, 0, 0, 1);
      else nop();
      checks++;
      if (obs !== want[i]) begin
        failures++;
        $display("FAIL cancel[%0d] obs=%b exp=%b",
                 i, obs, want[i]);
      end
    end
  endtask

  task automatic test_max_credit();
    step(1, 0, 0, 0, 0);
    repeat (9) coin(2'b10);
    coin(2'b01);
    coin(2'b10);
    checks++;
    if ({credit, reject} !== {5'd19, 1'b1}) begin
      failures++;
      $display("FAIL over_max credit=%0d reject=%b exp=19/1",
               credit, reject);
    end
    coin(2'b01);
    checks++;
    if ({credit, reject} !== {5'd20, 1'b0}) begin
      failures++;
      $display("FAIL at_max credit=%0d reject=%b exp=20/0",
               credit, reject);
    end
    coin(2'b11);
    checks++;
    if ({credit, reject} !== {5'd20, 1'b1}) begin
      failures++;
      $display("FAIL bad_coin credit=%0d reject=%b exp=20/1",
               credit, reject);
    end
    nop();
    checks++;
    if (reject !== 1'b0) begin
      failures++;
      $display("FAIL reject_pulse got=%b exp=0", reject);
    end
  endtask

  task automatic test_short_and_conflict();
    logic [12:0] want [4];
    want[0] = {1'b0, 2'd0, 2'b10, 5'd5, 3'b001};
    want[1] = {1'b0, 2'd0, 2'b10, 5'd3, 3'b001};
    want[2] = {1'b0, 2'd0, 2'b01, 5'd1, 3'b101};
    want[3] = {1'b0, 2'd0, 2'b00, 5'd0, 3'b000};
    step(1, 0, 0, 0, 0);
    coin(2'b10);
    step(0, 0, 2'd1, 1, 0);
    checks++;
    if (obs !== {1'b0, 2'd0, 2'b00, 5'd2, 3'b010}) begin
      failures++;
      $display("FAIL short obs=%b", obs);
    end
    coin(2'b01);
    coin(2'b10);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: step(0, 0, 2'd0, 1, 1);
        2: coin(2'b01);
        default: nop();
      endcase
      checks++;
      if (obs !== want[i]) begin
        failures++;
        $display("FAIL buy_cancel[%0d] obs=%b exp=%b",
                 i, obs, want[i]);
      end
    end
  endtask

  task automatic test_reset_mid_change();
    step(1, 0, 0, 0, 0);
    repeat (4) coin(2'b10);
    step(0, 0, 2'd0, 1, 0);
    checks++;
    if (obs !== {1'b1, 2'd0, 2'b00, 5'd5, 3'b001}) begin
      failures++;
      $display("FAIL mid_dispense obs=%b", obs);
    end
    nop();
    nop();
    checks++;
    if (obs !== {1'b0, 2'd0, 2'b10, 5'd3, 3'b001}) begin
      failures++;
      $display("FAIL mid_change2 obs=%b", obs);
    end
    step(1, 0, 0, 0, 0);
    checks++;
    if (obs !== 13'd0) begin
      failures++;
      $display("FAIL mid_reset obs=%b exp=0", obs);
    end
  endtask

  task automatic test_random();
    logic [1:0] c;
    logic r, b, x;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 79) == 0);
      c = ($urandom_range(0, 2) == 0) ? 2'b00
          : 2'($urandom_range(0, 3));
      b = ($urandom_range(0, 5) == 0);
      x = ($urandom_range(0, 11) == 0);
      step(r, c, 2'($urandom_range(0, 3)), b, x);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL random[%0d] obs=%b exp=%b",
                 i, obs, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1; in = 0; sel = 0; buy = 0; cancel = 0;
    test_reset();
    test_buy_with_change();
    test_exact_buy();
    test_cancel();
    test_max_credit();
    test_short_and_conflict();
    test_reset_mid_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/vending_machine_multi.md
VENDING_MACHINE_MULTI -- requirements
Module: vending_machine_multi

Interface
- REQ-001 The block SHALL provide these parameters:
  - CREDIT_W, 5, credit register width in Rs5 units.
  - NPROD, 4, number of products.
  - SEL_W, 2, product select width, equal to clog2(NPROD).
  - MAX_CREDIT, 20, maximum credit in Rs5 units (Rs100); must be at most 2^CREDIT_W-1.
  - PRICES, {5'd6,5'd5,5'd4,5'd3}, packed NPROD*CREDIT_W price list in Rs5 units; product i is at bits [i*CREDIT_W +: CREDIT_W]; defaults are Rs15/20/25/30.
- REQ-002 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
- REQ-003 The block SHALL provide these ports:
  - clk, input, 1, rising-edge clock.
  - rst, input, 1, synchronous active-high reset.
  - in, input, 2, coin per cycle: 00 none, 01 Rs5, 10 Rs10, 11 invalid.
  - sel, input, SEL_W, product index, sampled with buy.
  - buy, input, 1, purchase request, level-sampled each cycle.
  - cancel, input, 1, refund request, level-sampled each cycle.
  - out, output, 1, one-cycle dispense pulse.
  - prod, output, SEL_W, index of dispensed product, valid while out=1.
  - change, output, 2, returned coin per cycle: 00 none, 01 Rs5, 10 Rs10.
  - credit, output, CREDIT_W, current credit in Rs5 units.
  - reject, output, 1, one-cycle pulse when a coin is returned unaccepted.
  - short, output, 1, one-cycle pulse when buy is refused for insufficient credit.
  - busy, output, 1, high in DISPENSE or CHANGE.

Function
- REQ-004 The FSM SHALL have states IDLE, CREDIT, DISPENSE and CHANGE.
- REQ-005 Outputs out, prod, change, reject, short and busy SHALL all be registered.
- REQ-006 In IDLE/CREDIT, a coin of 01/10 with credit+value <= MAX_CREDIT SHALL add 1 or 2 units to credit in the next cycle; the state SHALL become CREDIT.
- REQ-007 A coin that would exceed MAX_CREDIT, a coin of 11, or any nonzero coin in DISPENSE/CHANGE SHALL leave credit unchanged and assert reject for one cycle.
- REQ-008 For buy in IDLE/CREDIT with credit >= PRICES[sel], the next cycle SHALL have state DISPENSE, out=1, prod=sel, and credit=credit-PRICES[sel].
- REQ-009 For buy with credit < PRICES[sel], the state and credit SHALL be unchanged and short SHALL assert for one cycle.
- REQ-010 From DISPENSE, the block SHALL go to CHANGE if credit>0, otherwise to IDLE; out SHALL be high for exactly one cycle.
- REQ-011 For cancel in IDLE/CREDIT, the block SHALL go to CHANGE next cycle with credit unchanged and no dispense; cancel with credit=0 SHALL be a no-op.
- REQ-012 In CHANGE, the block SHALL emit one coin per cycle: change=10 and credit-=2 while credit>=2, else change=01 and credit-=1; after the cycle in which credit reaches 0, the state SHALL be IDLE with change=00.
- REQ-013 In CHANGE, change SHALL be nonzero every cycle until credit is 0; the total returned SHALL equal the pre-CHANGE credit exactly.
- REQ-014 If cancel and buy are both high in the same cycle, cancel SHALL win and buy SHALL be ignored (no short).
- REQ-015 A coin arriving in the same cycle as a buy or cancel that is acted on SHALL be rejected (reject pulse) and not credited.
- REQ-016 buy and cancel SHALL be ignored while busy=1.
- REQ-017 busy SHALL be 1 exactly while the state is DISPENSE or CHANGE.

Reset
- REQ-018 rst=1 at a rising edge SHALL force the next state to IDLE with credit=0, out=0, prod=0, change=00, reject=0, short=0 and busy=0.
- REQ-019 Reset SHALL override all other inputs in that cycle; reset mid-CHANGE SHALL abort the refund, and the remaining credit is discarded.

Verification
- REQ-020 The bench SHALL cover these directed scenarios:
  - Defaults; rst, then in=10, in=10, then buy sel=0 -> credit 2 then 4; out=1, prod=0, credit=1; then change=01; then IDLE, credit=0.
  - Coins 10,10,10 (credit 6), buy sel=3 -> out=1, prod=3, credit=0, no change cycle, IDLE.
  - Credit 3, cancel -> change=10, then 01, then 00 with IDLE; out never asserted.
  - Credit 19, in=10 -> reject pulse, credit stays 19; then in=01 -> credit 20; in=11 anytime -> reject.
  - Credit 2, buy sel=1 -> short pulse, credit 2; buy+cancel same cycle with credit 5 -> refund 10,10,01 with no out; coin during CHANGE -> reject.
  - Credit 8, buy sel=0, rst asserted during the second CHANGE cycle -> next cycle IDLE, credit=0, change=00, busy=0.
